// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller: steps the accumulator increment from f_start to f_stop (optionally back down).
// Latency: first word one cycle after start is accepted; later words max(dwell,1) cycles apart.
// No backpressure: start is sampled only in IDLE; abort wins. Optional step_count output under DDS_SWEEP_STATUS_EN.
module dds_sweep_ctrl #(
  parameter int ACC_LENGTH  = 48,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic                   bidir,
  input  logic [ACC_LENGTH-1:0]  f_start,
  input  logic [ACC_LENGTH-1:0]  f_stop,
  input  logic [ACC_LENGTH-1:0]  f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [ACC_LENGTH-1:0]  increment,
  output logic                   load_increment,
  output logic                   busy,
  output logic                   done
`ifdef DDS_SWEEP_STATUS_EN
  ,
  output logic [15:0]            step_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, DWELL, STEP, FINISH} state_t;

  state_t                 state;
  logic [ACC_LENGTH-1:0]  c_start;
  logic [ACC_LENGTH-1:0]  c_stop;
  logic [ACC_LENGTH-1:0]  c_step;
  logic [DWELL_WIDTH-1:0] c_dwell_m1;
  logic [DWELL_WIDTH-1:0] cnt;
  logic                   c_bidir;
  logic                   c_cont;
  logic                   c_degen;
  logic                   dir_down;
  logic                   last_word;

  logic [DWELL_WIDTH-1:0] dwell_m1_in;
  logic                   degen_in;
  logic [ACC_LENGTH:0]    up_sum;
  logic [ACC_LENGTH:0]    dn_diff;
  logic [ACC_LENGTH-1:0]  up_word;
  logic [ACC_LENGTH-1:0]  dn_word;
  logic [ACC_LENGTH-1:0]  next_word;

  // Next word is derived from the word currently on the output; the extra bit catches carry/borrow.
  always_comb begin
    dwell_m1_in = (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
    degen_in    = (f_step == '0) || (f_stop <= f_start);
    up_sum      = {1'b0, increment} + {1'b0, c_step};
    dn_diff     = {1'b0, increment} - {1'b0, c_step};
    up_word     = (up_sum[ACC_LENGTH] || (up_sum[ACC_LENGTH-1:0] >= c_stop))
                  ? c_stop : up_sum[ACC_LENGTH-1:0];
    dn_word     = (dn_diff[ACC_LENGTH] || (dn_diff[ACC_LENGTH-1:0] <= c_start))
                  ? c_start : dn_diff[ACC_LENGTH-1:0];
    next_word   = dir_down ? dn_word : up_word;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      increment      <= '0;
      load_increment <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cnt            <= '0;
      c_start        <= '0;
      c_stop         <= '0;
      c_step         <= '0;
      c_dwell_m1     <= '0;
      c_bidir        <= 1'b0;
      c_cont         <= 1'b0;
      c_degen        <= 1'b0;
      dir_down       <= 1'b0;
      last_word      <= 1'b0;
    end else begin
      load_increment <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            c_start        <= f_start;
            c_stop         <= f_stop;
            c_step         <= f_step;
            c_dwell_m1     <= dwell_m1_in;
            c_bidir        <= bidir;
            c_cont         <= continuous;
            c_degen        <= degen_in;
            last_word      <= degen_in;
            dir_down       <= 1'b0;
            cnt            <= dwell_m1_in;
            increment      <= f_start;
            load_increment <= 1'b1;
            busy           <= 1'b1;
            state          <= LOAD;
          end
        end
        LOAD, DWELL, STEP, FINISH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (state == FINISH) begin
            if (c_cont) begin
              last_word      <= c_degen;
              dir_down       <= 1'b0;
              cnt            <= c_dwell_m1;
              increment      <= c_start;
              load_increment <= 1'b1;
              state          <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (cnt != '0) begin
            // STEP is the final dwell cycle, in which the next word is computed.
            cnt   <= cnt - DWELL_WIDTH'(1);
            state <= (cnt == DWELL_WIDTH'(1)) ? STEP : DWELL;
          end else if (last_word) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            increment      <= next_word;
            load_increment <= 1'b1;
            cnt            <= c_dwell_m1;
            state          <= (c_dwell_m1 == '0) ? STEP : DWELL;
            if (!dir_down && (up_word == c_stop)) begin
              if (c_bidir) dir_down  <= 1'b1;
              else         last_word <= 1'b1;
            end else if (dir_down && (dn_word == c_start)) begin
              last_word <= 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DDS_SWEEP_STATUS_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      step_count <= '0;
    end else if (load_increment && (step_count != 16'hFFFF)) begin
      step_count <= step_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table-driven sweeps, randomized sweeps against a word-list model, hand corner cases.
module tb_dds_sweep_ctrl;
  localparam int AW = 48;
  localparam int DW = 24;
  localparam logic [AW-1:0] MAXW = {AW{1'b1}};

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          continuous = 1'b0;
  logic          bidir = 1'b0;
  logic [AW-1:0] f_start = '0;
  logic [AW-1:0] f_stop = '0;
  logic [AW-1:0] f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [AW-1:0] increment;
  logic          load_increment;
  logic          busy;
  logic          done;
`ifdef DDS_SWEEP_STATUS_EN
  logic [15:0]   step_count;
`endif

  dds_sweep_ctrl #(.ACC_LENGTH(AW), .DWELL_WIDTH(DW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .continuous(continuous), .bidir(bidir), .f_start(f_start), .f_stop(f_stop),
    .f_step(f_step), .dwell(dwell), .increment(increment),
    .load_increment(load_increment), .busy(busy), .done(done)
`ifdef DDS_SWEEP_STATUS_EN
    , .step_count(step_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] fs;
    logic [AW-1:0] fe;
    logic [AW-1:0] st;
    logic [DW-1:0] dw;
    logic          bd;
    int            exp_n;
    logic [AW-1:0] exp_last;
    int            exp_done;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected word list, straight from the sweep rules with wide arithmetic.
  task automatic model(input logic [AW-1:0] fs, input logic [AW-1:0] fe,
                       input logic [AW-1:0] st, input logic bd);
    logic [AW+1:0] w;
    exp_q.delete();
    exp_q.push_back(fs);
    if (st != '0 && fe > fs) begin
      w = {2'b00, fs};
      while (w < {2'b00, fe}) begin
        w = w + {2'b00, st};
        if (w > {2'b00, fe}) w = {2'b00, fe};
        exp_q.push_back(w[AW-1:0]);
      end
      if (bd) begin
        while (w > {2'b00, fs}) begin
          if (w <= {2'b00, fs} + {2'b00, st}) w = {2'b00, fs};
          else w = w - {2'b00, st};
          exp_q.push_back(w[AW-1:0]);
        end
      end
    end
  endtask

  task automatic run_sweep(input string tag, input logic [AW-1:0] fs, input logic [AW-1:0] fe,
                           input logic [AW-1:0] st, input logic [DW-1:0] dw, input logic bd,
                           output int n, output logic [AW-1:0] last, output int done_t);
    int d;
    int budget;
    logic [AW-1:0] prev;
    logic unstable;
    logic busy_drop;
    model(fs, fe, st, bd);
    d = (dw == '0) ? 1 : int'(dw);
    budget = exp_q.size() * d + 8;
    n = 0;
    last = '0;
    done_t = -1;
    unstable = 1'b0;
    busy_drop = 1'b0;
    @(negedge sys_clk);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; bidir = bd; continuous = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    prev = increment;
    for (int t = 1; t <= budget; t++) begin
      if (t > 1) @(negedge sys_clk);
      if (load_increment) begin
        if (n < exp_q.size()) check($sformatf("%s word%0d", tag, n), increment, exp_q[n]);
        check($sformatf("%s time%0d", tag, n), t, 1 + n * d);
        n++;
        last = increment;
      end else if (increment !== prev) begin
        unstable = 1'b1;
      end
      prev = increment;
      if (!busy) busy_drop = 1'b1;
      if (done) begin
        done_t = t;
        break;
      end
      if (t == 1) begin
        // Inputs change mid-sweep; the captured values must rule.
        f_start = {$urandom, $urandom}; f_stop = {$urandom, $urandom};
        f_step = {$urandom, $urandom}; dwell = DW'($urandom_range(0, 5));
        bidir = 1'($urandom); continuous = 1'($urandom);
      end
    end
    check($sformatf("%s nloads", tag), n, exp_q.size());
    check($sformatf("%s done_cycle", tag), done_t, 1 + exp_q.size() * d);
    check($sformatf("%s stable", tag), {63'd0, unstable}, 64'd0);
    check($sformatf("%s busy_during", tag), {63'd0, busy_drop}, 64'd0);
    @(negedge sys_clk);
    check($sformatf("%s busy_after", tag), {63'd0, busy}, 64'd0);
    check($sformatf("%s load_after", tag), {63'd0, load_increment}, 64'd0);
    continuous = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int n;
    int done_t;
    int cnt_ld;
    int cnt_dn;
    logic [AW-1:0] last;
    logic [AW-1:0] fs;
    logic [AW-1:0] fe;
    logic [AW-1:0] st;
    logic [AW:0]   tmp;
    int span;
    int mode;

    vt[0] = '{100, 400, 100, 3, 1'b0, 4, 400, 13};
    vt[1] = '{100, 350, 100, 3, 1'b0, 4, 350, 13};
    vt[2] = '{100, 400, 100, 3, 1'b1, 7, 100, 22};
    vt[3] = '{48'hFFFF_FFFF_FFF6, MAXW, 50, 2, 1'b0, 2, MAXW, 5};
    vt[4] = '{100, 400, 0, 4, 1'b0, 1, 100, 5};
    vt[5] = '{500, 500, 10, 1, 1'b0, 1, 500, 2};
    vt[6] = '{0, 30, 10, 0, 1'b1, 7, 0, 8};
    vt[7] = '{600, 100, 5, 2, 1'b1, 1, 600, 3};
    vt[8] = '{0, 25, 10, 1, 1'b1, 7, 0, 8};

    #12;
    check("reset increment", increment, 0);
    check("reset load", {63'd0, load_increment}, 0);
    check("reset busy", {63'd0, busy}, 0);
    check("reset done", {63'd0, done}, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 9; i++) begin
      run_sweep($sformatf("vec%0d", i), vt[i].fs, vt[i].fe, vt[i].st, vt[i].dw, vt[i].bd,
                n, last, done_t);
      check($sformatf("vec%0d hand_n", i), n, vt[i].exp_n);
      check($sformatf("vec%0d hand_last", i), last, vt[i].exp_last);
      check($sformatf("vec%0d hand_done", i), done_t, vt[i].exp_done);
    end

    for (int r = 0; r < 24; r++) begin
      span = $urandom_range(0, 2000);
      mode = $urandom_range(0, 3);
      fs = AW'($urandom_range(0, 5000));
      if (mode == 0) begin
        fe = (fs > AW'(span)) ? fs - AW'(span) : '0;
      end else if (mode == 1) begin
        fs = MAXW - AW'($urandom_range(0, 3000));
        tmp = {1'b0, fs} + (AW + 1)'(span);
        fe = tmp[AW] ? MAXW : tmp[AW-1:0];
      end else begin
        fe = fs + AW'(span);
      end
      st = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(span / 8 + 1, span + 100));
      run_sweep($sformatf("rnd%0d", r), fs, fe, st, DW'($urandom_range(0, 4)),
                1'($urandom), n, last, done_t);
    end

    // Abort in the dwell of the second word.
    @(negedge sys_clk);
    f_start = 100; f_stop = 400; f_step = 100; dwell = 3; bidir = 1'b0; continuous = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int t = 2; t <= 5; t++) begin
      @(negedge sys_clk);
      if (t == 4) begin
        check("abort 2nd load strobe", {63'd0, load_increment}, 1);
        check("abort 2nd load value", increment, 200);
      end
    end
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    check("abort busy", {63'd0, busy}, 0);
    check("abort increment", increment, 200);
    cnt_ld = 0;
    cnt_dn = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge sys_clk);
      if (load_increment) cnt_ld++;
      if (done) cnt_dn++;
    end
    check("abort no strobes", cnt_ld, 0);
    check("abort no done", cnt_dn, 0);
    check("abort hold increment", increment, 200);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", {63'd0, busy}, 0);
    check("start+abort load", {63'd0, load_increment}, 0);
    @(negedge sys_clk);
    check("start+abort busy later", {63'd0, busy}, 0);

    // Continuous, dwell 0: strobe every cycle, reload right after done.
    f_start = 0; f_stop = 20; f_step = 10; dwell = 0; bidir = 1'b0; continuous = 1'b1;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      if (t > 1) @(negedge sys_clk);
      case (t)
        1: begin check("cont t1 load", {63'd0, load_increment}, 1); check("cont t1 inc", increment, 0); end
        2: begin check("cont t2 load", {63'd0, load_increment}, 1); check("cont t2 inc", increment, 10); end
        3: begin check("cont t3 load", {63'd0, load_increment}, 1); check("cont t3 inc", increment, 20); end
        4: begin check("cont t4 done", {63'd0, done}, 1); check("cont t4 load", {63'd0, load_increment}, 0);
                 check("cont t4 busy", {63'd0, busy}, 1); end
        5: begin check("cont t5 reload", {63'd0, load_increment}, 1); check("cont t5 inc", increment, 0);
                 check("cont t5 done", {63'd0, done}, 0); end
        default: begin check("cont t6 load", {63'd0, load_increment}, 1); check("cont t6 inc", increment, 10); end
      endcase
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst increment", increment, 0);
    check("async rst load", {63'd0, load_increment}, 0);
    check("async rst busy", {63'd0, busy}, 0);
    check("async rst done", {63'd0, done}, 0);
    continuous = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    cnt_ld = 0;
    cnt_dn = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge sys_clk);
      if (load_increment || busy) cnt_ld++;
      if (done) cnt_dn++;
    end
    check("post-reset idle", cnt_ld, 0);
    check("post-reset no done", cnt_dn, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_LENGTH, default 48, the increment word width, matching the phase accumulator.
REQ-002 SHALL have parameter DWELL_WIDTH, default 24, the dwell counter width.
REQ-003 SHALL have port sys_clk  input  1  the system clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  sweep start request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminates the sweep and returns to IDLE.
REQ-007 SHALL have port continuous  input  1  1 = restart the sweep after completion, 0 = single sweep.
REQ-008 SHALL have port bidir  input  1  1 = ramp up to f_stop then back down to f_start, 0 = up only.
REQ-009 SHALL have ports f_start, f_stop, f_step  input  ACC_LENGTH  the sweep start, end and step increments.
REQ-010 SHALL have port dwell  input  DWELL_WIDTH  sys_clk cycles per step; 0 is treated as 1.
REQ-011 SHALL have port increment  output  ACC_LENGTH  the frequency word presented to the phase accumulator.
REQ-012 SHALL have port load_increment  output  1  one-cycle strobe, high while increment holds a new valid value.
REQ-013 SHALL have ports busy  output  1  (high outside IDLE) and done  output  1  (one-cycle pulse on sweep completion).

Function
REQ-014 SHALL implement the states IDLE, LOAD, DWELL, STEP and FINISH.
REQ-015 SHALL, in IDLE, on start=1 and abort=0 at edge k, capture all of f_start, f_stop, f_step, dwell, bidir and continuous, then enter LOAD.
REQ-016 SHALL, in LOAD (cycle k+1), drive increment=f_start and load_increment=1, then enter DWELL.
REQ-017 SHALL space consecutive load_increment pulses exactly max(dwell,1) cycles apart.
REQ-018 SHALL compute the next word in STEP, with the result visible one cycle later together with load_increment.
REQ-019 SHALL compute the up direction as cur+f_step with an ACC_LENGTH+1-bit sum; a result >= f_stop or a carry clamps to f_stop, and the word equal to f_stop is the last up step.
REQ-020 SHALL compute the down direction (bidir=1, after f_stop) as cur-f_step; a result <= f_start or a borrow clamps to f_start, and the word equal to f_start is the last step.
REQ-021 SHALL treat f_step==0 or f_stop<=f_start as a degenerate sweep: exactly one load of f_start, one dwell, then FINISH.
REQ-022 SHALL, after the final word's dwell expires, enter FINISH for exactly one cycle: done=1, busy=1.
REQ-023 SHALL go from FINISH to IDLE if continuous=0, or to LOAD (f_start reloaded) if continuous=1.
REQ-024 SHALL, on abort=1 in any non-IDLE state, enter IDLE on the next edge, with no further load_increment and no done; increment holds its last value.
REQ-025 SHALL give abort priority over start when both are high; start while busy SHALL be ignored.
REQ-026 SHALL not let input changes during a sweep affect it; the captured values are used.
REQ-027 SHALL keep increment stable between strobes.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, increment=0, load_increment=0, busy=0, done=0, dwell counter=0.
REQ-029 SHALL, when reset is asserted mid-sweep, abandon the sweep without a done pulse and require a new start after release.

Configuration
REQ-030 SHALL, with DDS_SWEEP_STATUS_EN defined, add output step_count (16 bits): cleared on start acceptance and on reset, +1 per load_increment, saturating at 16'hFFFF.
REQ-031 SHALL, without DDS_SWEEP_STATUS_EN, have neither the port nor the counter, with all other behaviour identical.

Verification
REQ-032 SHALL verify: f_start=100, f_stop=400, f_step=100, dwell=3, bidir=0 -> loads of 100, 200, 300, 400 at cycles k+1, k+4, k+7, k+10, then done at k+13, then busy=0.
REQ-033 SHALL verify: f_start=100, f_stop=350, f_step=100 -> last load 350 (clamped), then done.
REQ-034 SHALL verify: bidir=1 with REQ-032 values -> 100, 200, 300, 400, 300, 200, 100, then done.
REQ-035 SHALL verify: f_start=2^48-10, f_stop=2^48-1, f_step=50 -> second load 2^48-1 (carry clamp).
REQ-036 SHALL verify: abort one cycle after the 2nd load -> no further strobes, no done, increment=200, busy=0 next cycle; start+abort together in IDLE -> stays IDLE.
REQ-037 SHALL verify: continuous=1, dwell=0 -> loads every cycle, done pulse, f_start reloaded the cycle after done; rst_n low mid-sweep -> all outputs 0 asynchronously.
